// File: rtl/tree_prior_sel_pipe.sv
// Pipelined N-input priority-select tree with valid/ready flow control.
// Each frame of N candidates is reduced to the valid candidate with the smallest
// priority. Ties go to the lower input position. One tree level is one pipeline stage.
// Optional feature macro: TREE_PRIOR_SEL_HITCNT_EN adds result_cnt, the number of
// valid candidates in the frame. It is computed by a pipelined adder tree that is
// aligned with the select tree.
// Nodes are stored heap-style. Node 1 is the root, and node i has children 2i and 2i+1.
// A child index >= N names leaf (index - N), which is driven straight from the inputs.
`timescale 1ns/1ps
module tree_prior_sel_pipe #(
    parameter int unsigned N       = 8,
    parameter int unsigned PRIOR_W = 8,
    parameter int unsigned INDEX_W = 8,
    localparam int unsigned LEVELS = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         sel_valid,
    input  logic [N*PRIOR_W-1:0] sel_prior,
    input  logic [N*INDEX_W-1:0] sel_index,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef TREE_PRIOR_SEL_HITCNT_EN
    output logic [LEVELS:0]      result_cnt,
`endif
    output logic                 result_hit,
    output logic [PRIOR_W-1:0]   result_prior,
    output logic [INDEX_W-1:0]   result_index,
    output logic [LEVELS-1:0]    result_pos
);

    localparam int NI    = int'(N);
    localparam int CNT_W = int'(LEVELS) + 1;

    logic w_advance;

    // Frame tokens per level. Level LEVELS is the output stage.
    logic [LEVELS:1] r_tok;

    // Leaf (input) view of each candidate.
    logic               w_leaf_hit   [N];
    logic [PRIOR_W-1:0] w_leaf_prior [N];
    logic [INDEX_W-1:0] w_leaf_index [N];
    logic [LEVELS-1:0]  w_leaf_pos   [N];

    // Registered tree nodes 1..N-1, with their next-state values.
    logic               r_hit   [1:N-1];
    logic [PRIOR_W-1:0] r_prior [1:N-1];
    logic [INDEX_W-1:0] r_index [1:N-1];
    logic [LEVELS-1:0]  r_pos   [1:N-1];
    logic               w_hit   [1:N-1];
    logic [PRIOR_W-1:0] w_prior [1:N-1];
    logic [INDEX_W-1:0] w_index [1:N-1];
    logic [LEVELS-1:0]  w_pos   [1:N-1];

`ifdef TREE_PRIOR_SEL_HITCNT_EN
    logic [CNT_W-1:0] w_leaf_cnt [N];
    logic [CNT_W-1:0] r_cnt      [1:N-1];
    logic [CNT_W-1:0] w_cnt      [1:N-1];
`endif

    // The whole pipeline moves together. It holds only while a result waits at the output.
    assign w_advance = !r_tok[LEVELS] || out_ready;
    assign in_ready  = w_advance;

    // Leaves are gated by in_valid, so bubbles carry all-zero data.
    always_comb begin
        for (int p = 0; p < NI; p++) begin
            w_leaf_hit[p]   = in_valid & sel_valid[p];
            w_leaf_prior[p] = w_leaf_hit[p] ? sel_prior[PRIOR_W*p +: PRIOR_W] : '0;
            w_leaf_index[p] = w_leaf_hit[p] ? sel_index[INDEX_W*p +: INDEX_W] : '0;
            w_leaf_pos[p]   = LEVELS'(p);
`ifdef TREE_PRIOR_SEL_HITCNT_EN
            w_leaf_cnt[p]   = CNT_W'(w_leaf_hit[p]);
`endif
        end
    end

    // Compare each pair of children. Child a is at the lower position.
    always_comb begin
        logic               a_hit, b_hit, b_win;
        logic [PRIOR_W-1:0] a_pr, b_pr;
        logic [INDEX_W-1:0] a_ix, b_ix;
        logic [LEVELS-1:0]  a_ps, b_ps;
`ifdef TREE_PRIOR_SEL_HITCNT_EN
        logic [CNT_W-1:0]   a_ct, b_ct;
`endif
        int                 c;
        for (int i = 1; i < NI; i++) begin
            c = 2 * i;
            if (c >= NI) begin
                a_hit = w_leaf_hit[c-NI];     b_hit = w_leaf_hit[c+1-NI];
                a_pr  = w_leaf_prior[c-NI];   b_pr  = w_leaf_prior[c+1-NI];
                a_ix  = w_leaf_index[c-NI];   b_ix  = w_leaf_index[c+1-NI];
                a_ps  = w_leaf_pos[c-NI];     b_ps  = w_leaf_pos[c+1-NI];
`ifdef TREE_PRIOR_SEL_HITCNT_EN
                a_ct  = w_leaf_cnt[c-NI];     b_ct  = w_leaf_cnt[c+1-NI];
`endif
            end else begin
                a_hit = r_hit[c];   b_hit = r_hit[c+1];
                a_pr  = r_prior[c]; b_pr  = r_prior[c+1];
                a_ix  = r_index[c]; b_ix  = r_index[c+1];
                a_ps  = r_pos[c];   b_ps  = r_pos[c+1];
`ifdef TREE_PRIOR_SEL_HITCNT_EN
                a_ct  = r_cnt[c];   b_ct  = r_cnt[c+1];
`endif
            end
            // b wins only if it is valid and a is either invalid or has a strictly larger priority.
            b_win      = b_hit && (!a_hit || (b_pr < a_pr));
            w_hit[i]   = a_hit | b_hit;
            w_prior[i] = '0;
            w_index[i] = '0;
            w_pos[i]   = '0;
            if (b_win) begin
                w_prior[i] = b_pr;
                w_index[i] = b_ix;
                w_pos[i]   = b_ps;
            end else if (a_hit) begin
                w_prior[i] = a_pr;
                w_index[i] = a_ix;
                w_pos[i]   = a_ps;
            end
`ifdef TREE_PRIOR_SEL_HITCNT_EN
            w_cnt[i] = a_ct + b_ct;
`endif
        end
    end

    // Stage registers. Every level loads only when the pipeline advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tok <= '0;
            for (int i = 1; i < NI; i++) begin
                r_hit[i]   <= 1'b0;
                r_prior[i] <= '0;
                r_index[i] <= '0;
                r_pos[i]   <= '0;
`ifdef TREE_PRIOR_SEL_HITCNT_EN
                r_cnt[i]   <= '0;
`endif
            end
        end else if (w_advance) begin
            r_tok[1] <= in_valid;
            for (int k = 2; k <= int'(LEVELS); k++) begin
                r_tok[k] <= r_tok[k-1];
            end
            for (int i = 1; i < NI; i++) begin
                r_hit[i]   <= w_hit[i];
                r_prior[i] <= w_prior[i];
                r_index[i] <= w_index[i];
                r_pos[i]   <= w_pos[i];
`ifdef TREE_PRIOR_SEL_HITCNT_EN
                r_cnt[i]   <= w_cnt[i];
`endif
            end
        end
    end

    assign out_valid    = r_tok[LEVELS];
    assign result_hit   = r_hit[1];
    assign result_prior = r_prior[1];
    assign result_index = r_index[1];
    assign result_pos   = r_pos[1];
`ifdef TREE_PRIOR_SEL_HITCNT_EN
    assign result_cnt   = r_cnt[1];
`endif

endmodule
